// File: rtl/stack_unit_if.sv
// Bundles the stack command, data and status signals between the stack_unit and its user.
// The ovf/unf error flags exist only when STACK_ERR_EN is defined.
interface stack_unit_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic             push;
    logic             pop;
    logic             tos;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
`ifdef STACK_ERR_EN
    logic             ovf;
    logic             unf;
`endif

`ifdef STACK_ERR_EN
    modport master (
        output push, pop, tos, din,
        input  dout, valid, empty, full, count, ovf, unf
    );
    modport slave (
        input  push, pop, tos, din,
        output dout, valid, empty, full, count, ovf, unf
    );
`else
    modport master (
        output push, pop, tos, din,
        input  dout, valid, empty, full, count
    );
    modport slave (
        input  push, pop, tos, din,
        output dout, valid, empty, full, count
    );
`endif
endinterface

// File: rtl/stack_unit.sv
// LIFO stack with registered one-cycle read data, driven by an EMPTY/PART/FULL state machine.
// Define STACK_ERR_EN to add sticky overflow (ovf) and underflow (unf) flags.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic         clk,
    input logic         rst,
    stack_unit_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PART,
        S_FULL
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             isEmpty;
    logic             isFull;
    logic             popEff;
    logic             readEn;
    logic             replaceEn;
    logic             growEn;
    logic             shrinkEn;
    logic             writeEn;
    logic [CW-1:0]    topCount;
    logic [AW-1:0]    topIdx;
    logic [AW-1:0]    writeIdx;

    // Operation decode: a push together with an effective pop replaces the top in place.
    always_comb begin
        isEmpty   = (state_q == S_EMPTY);
        isFull    = (state_q == S_FULL);
        popEff    = bus.pop && !isEmpty;
        readEn    = (bus.pop || bus.tos) && !isEmpty;
        replaceEn = bus.push && popEff;
        growEn    = bus.push && !popEff && !isFull;
        shrinkEn  = popEff && !bus.push;
        writeEn   = replaceEn || growEn;
        topCount  = count_q - CW'(1);
        topIdx    = topCount[AW-1:0];
        writeIdx  = replaceEn ? topIdx : count_q[AW-1:0];
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dout_d  = dout_q;
        valid_d = 1'b0;

        if (readEn) begin
            dout_d  = mem_q[topIdx];
            valid_d = 1'b1;
        end

        if (growEn) begin
            count_d = count_q + CW'(1);
        end else if (shrinkEn) begin
            count_d = count_q - CW'(1);
        end

        case (state_q)
            S_EMPTY: begin
                if (growEn) begin
                    state_d = S_PART;
                end
            end
            S_PART: begin
                if (growEn && (count_q == CW'(DEPTH - 1))) begin
                    state_d = S_FULL;
                end else if (shrinkEn && (count_q == CW'(1))) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (shrinkEn) begin
                    state_d = S_PART;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem_q[writeIdx] <= bus.din;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
    assign bus.empty = (state_q == S_EMPTY);
    assign bus.full  = (state_q == S_FULL);
    assign bus.count = count_q;

`ifdef STACK_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // A push+pop on an empty stack acts as a plain push, so it is not an underflow.
    always_comb begin
        ovf_d = ovf_q || (bus.push && isFull && !bus.pop);
        unf_d = unf_q || ((bus.pop || bus.tos) && isEmpty && !bus.push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.unf = unf_q;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit (WIDTH=8, DEPTH=4): directed scenarios then random traffic,
// compared against a queue-based LIFO model.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    logic [WIDTH-1:0] modelStack[$];
    logic [WIDTH-1:0] modelDout;
    logic             modelValid;
    logic             modelOvf;
    logic             modelUnf;

    stack_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) bus ();

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        modelStack.delete();
        modelDout  = '0;
        modelValid = 1'b0;
        modelOvf   = 1'b0;
        modelUnf   = 1'b0;
    endtask

    // LIFO behaviour: a read returns the pre-edge top; push+pop on a non-empty stack swaps the top.
    task automatic modelStep(input logic push, input logic pop, input logic tos, input logic [WIDTH-1:0] din);
        bit wasEmpty;
        wasEmpty   = (modelStack.size() == 0);
        modelValid = 1'b0;
        if ((pop || tos) && !wasEmpty) begin
            modelDout  = modelStack[$];
            modelValid = 1'b1;
        end
        if ((pop || tos) && wasEmpty && !push) modelUnf = 1'b1;
        if (push && pop && !wasEmpty) begin
            modelStack[modelStack.size() - 1] = din;
        end else if (pop && !wasEmpty) begin
            void'(modelStack.pop_back());
        end else if (push) begin
            if (modelStack.size() < DEPTH) modelStack.push_back(din);
            else modelOvf = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, ".dout"},  32'(bus.dout),  32'(modelDout));
        compare({tag, ".valid"}, 32'(bus.valid), 32'(modelValid));
        compare({tag, ".count"}, 32'(bus.count), 32'(modelStack.size()));
        compare({tag, ".empty"}, 32'(bus.empty), 32'(modelStack.size() == 0));
        compare({tag, ".full"},  32'(bus.full),  32'(modelStack.size() == DEPTH));
`ifdef STACK_ERR_EN
        compare({tag, ".ovf"},   32'(bus.ovf),   32'(modelOvf));
        compare({tag, ".unf"},   32'(bus.unf),   32'(modelUnf));
`endif
    endtask

    // Drives one cycle of commands, advances past the edge and checks against the model.
    task automatic applyStimulus(input string tag, input logic push, input logic pop, input logic tos,
                                 input logic [WIDTH-1:0] din);
        bus.push = push;
        bus.pop  = pop;
        bus.tos  = tos;
        bus.din  = din;
        @(posedge clk);
        #1;
        modelStep(push, pop, tos, din);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.tos  = 1'b0;
        checkOutput(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.tos     = 1'b0;
        bus.din     = '0;
        modelReset();

        rst = 1'b1;
        #1;
        checkOutput("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Push three, pop three in LIFO order.
        applyStimulus("r37_push11", 1, 0, 0, 8'h11);
        applyStimulus("r37_push22", 1, 0, 0, 8'h22);
        applyStimulus("r37_push33", 1, 0, 0, 8'h33);
        applyStimulus("r37_pop1", 0, 1, 0, 8'h00);
        compare("r37_pop1_const", 32'(bus.dout), 32'h33);
        applyStimulus("r37_pop2", 0, 1, 0, 8'h00);
        compare("r37_pop2_const", 32'(bus.dout), 32'h22);
        applyStimulus("r37_pop3", 0, 1, 0, 8'h00);
        compare("r37_pop3_const", 32'(bus.dout), 32'h11);
        applyStimulus("r37_idle", 0, 0, 0, 8'h00);

        // Simultaneous push and pop replaces the top.
        applyStimulus("r40_push01", 1, 0, 0, 8'h01);
        applyStimulus("r40_push02", 1, 0, 0, 8'h02);
        applyStimulus("r40_swap77", 1, 1, 0, 8'h77);
        compare("r40_swap_const", 32'(bus.dout), 32'h02);
        applyStimulus("r40_pop77", 0, 1, 0, 8'h00);
        compare("r40_pop_const", 32'(bus.dout), 32'h77);
        applyStimulus("r40_pop01", 0, 1, 0, 8'h00);

        // Push+pop while full is legal and does not overflow.
        for (int i = 0; i < DEPTH; i++) applyStimulus("r42_fill", 1, 0, 0, 8'(8'hB0 + i));
        applyStimulus("r42_swap99", 1, 1, 0, 8'h99);
        compare("r42_swap_const", 32'(bus.dout), 32'hB3);
        applyStimulus("r42_pop99", 0, 1, 0, 8'h00);
        compare("r42_pop_const", 32'(bus.dout), 32'h99);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus("r42_drain", 0, 1, 0, 8'h00);

        // Push while full is dropped.
        for (int i = 0; i < DEPTH; i++) applyStimulus("r38_fill", 1, 0, 0, 8'(8'hA0 + i));
        compare("r38_full_const", 32'(bus.full), 32'h1);
        applyStimulus("r38_pushFF", 1, 0, 0, 8'hFF);
        applyStimulus("r38_pop", 0, 1, 0, 8'h00);
        compare("r38_pop_const", 32'(bus.dout), 32'hA3);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus("r38_drain", 0, 1, 0, 8'h00);

        // Reads on an empty stack, push+pop on empty, then tos.
        applyStimulus("r39_popEmpty", 0, 1, 0, 8'h00);
        applyStimulus("r39_tosEmpty", 0, 0, 1, 8'h00);
        applyStimulus("r39_pushPop5A", 1, 1, 0, 8'h5A);
        applyStimulus("r39_tos", 0, 0, 1, 8'h00);
        compare("r39_tos_const", 32'(bus.dout), 32'h5A);
        applyStimulus("r39_popTos", 0, 1, 1, 8'h00);
        applyStimulus("r26_push44", 1, 0, 0, 8'h44);
        applyStimulus("r26_pushTos", 1, 0, 1, 8'h45);
        compare("r26_pushTos_const", 32'(bus.dout), 32'h44);

        // Asynchronous reset during a pop from a three-deep stack.
        applyStimulus("r41_push", 1, 0, 0, 8'hC1);
        compare("r41_count3", 32'(bus.count), 32'h3);
        bus.pop = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("r41_async");
        bus.pop = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("r41_held");
        rst = 1'b0;
        applyStimulus("r41_after", 0, 1, 0, 8'h00);
        applyStimulus("r41_push", 1, 0, 0, 8'hD7);
        applyStimulus("r41_tos", 0, 0, 1, 8'h00);

        // Random traffic biased to exercise both the full and empty boundaries.
        for (int i = 0; i < 400; i++) begin
            logic p, q, t;
            p = ($urandom_range(0, 99) < 50);
            q = ($urandom_range(0, 99) < 40);
            t = ($urandom_range(0, 99) < 20);
            applyStimulus("rand", p, q, t, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, at least 2.
REQ-003 Parameter CW, default $clog2(DEPTH)+1, width of the occupancy count.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 push  input  1  write din onto the top of the stack.
REQ-007 pop  input  1  remove the top entry and return it on dout.
REQ-008 tos  input  1  return the top entry on dout without removing it.
REQ-009 din  input  WIDTH  push data.
REQ-010 dout  output  WIDTH  registered read data (pop or tos).
REQ-011 valid  output  1  one-cycle pulse; dout was updated this cycle.
REQ-012 empty  output  1  registered; count == 0.
REQ-013 full  output  1  registered; count == DEPTH.
REQ-014 count  output  CW  number of stored entries, 0..DEPTH.
REQ-015 ovf, unf  output  1 each  sticky error flags; present only under STACK_ERR_EN.

Function
REQ-016 Storage SHALL be a DEPTH x WIDTH register array with stack pointer sp == count; a push writes mem[sp], and pop/tos read mem[sp-1].
REQ-017 Control SHALL be an explicit three-state FSM: S_EMPTY, S_PART, S_FULL; empty = (state == S_EMPTY) and full = (state == S_FULL).
REQ-018 S_EMPTY: push -> S_PART (S_FULL if DEPTH == 1 is excluded by REQ-002); pop or tos -> stay, no effect.
REQ-019 S_PART: net +1 reaching DEPTH -> S_FULL; net -1 reaching 0 -> S_EMPTY; otherwise stay.
REQ-020 S_FULL: pop -> S_PART; push without pop -> stay, ignored.
REQ-021 Read latency SHALL be one cycle: pop or tos sampled at edge N puts the pre-edge top on dout with valid=1 after edge N.
REQ-022 dout SHALL hold its last value when no valid read occurs; valid SHALL be 0 in every cycle without a valid read.
REQ-023 push&pop in the same cycle while non-empty SHALL return the old top on dout (valid=1), overwrite mem[sp-1] with din, and leave count unchanged; this is legal in S_FULL.
REQ-024 push&pop in the same cycle while empty SHALL behave as push only; valid=0.
REQ-025 pop&tos in the same cycle SHALL behave as pop only.
REQ-026 push&tos in the same cycle while non-empty SHALL return the old top and then push din; count increments.
REQ-027 push while full, or pop/tos while empty, SHALL leave the memory, count, state and dout unchanged.
REQ-028 count SHALL never wrap past DEPTH or below 0.

Reset
REQ-029 rst SHALL immediately force: state S_EMPTY, count 0, empty 1, full 0, dout 0, valid 0, and ovf/unf 0.
REQ-030 Memory contents SHALL NOT be reset; they are unreachable until rewritten.
REQ-031 rst asserted mid-operation SHALL discard all entries and any read in flight; the first edge after rst deasserts is treated as an ordinary cycle.

Configuration
REQ-032 Macro STACK_ERR_EN: when defined, ovf and unf ports SHALL exist.
REQ-033 With STACK_ERR_EN, ovf SHALL set on a push while full without a simultaneous pop.
REQ-034 With STACK_ERR_EN, unf SHALL set on a pop or tos while empty.
REQ-035 With STACK_ERR_EN, both flags SHALL be sticky and clear only on rst.
REQ-036 Without STACK_ERR_EN, the ports and logic SHALL be absent, and illegal operations are silently ignored per REQ-027.

Verification (WIDTH=8, DEPTH=4)
REQ-037 Push 0x11, 0x22, 0x33, then pop x3 -> dout 0x33, 0x22, 0x11 with valid=1 one cycle after each pop; count ends 0; empty=1.
REQ-038 Push 4 values (0xA0..0xA3) -> full=1, count=4; a fifth push of 0xFF is ignored (ovf=1 if STACK_ERR_EN); pop -> dout 0xA3.
REQ-039 From empty: pop -> valid=0, dout unchanged, count=0 (unf=1 if STACK_ERR_EN); push&pop of 0x5A -> count=1, valid=0; tos -> dout 0x5A, count=1.
REQ-040 Stack holds 0x01, 0x02 (top) -> push&pop of 0x77 -> dout 0x02, count=2; next pop -> dout 0x77.
REQ-041 Stack at count=3; assert rst mid-cycle during a pop -> count=0, empty=1, valid=0, dout=0 immediately; flags cleared.
REQ-042 Full stack: push&pop of 0x99 -> dout = old top, full stays 1, no ovf; pop -> dout 0x99.
